// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg: shared uop layout, next-field codes and sequencer state encodings
package dzcpu_useq_pkg;
    localparam int UPC_W = 8;
    localparam int UOP_W = 13;
    localparam int DEF_MAX_FLOW_LEN = 32;

    localparam int NXT_HI = 12;
    localparam int NXT_LO = 9;
    localparam int OP_HI = 8;
    localparam int OP_LO = 4;
    localparam int OPR_HI = 3;
    localparam int OPR_LO = 0;

    localparam logic [3:0] NX_OP = 4'd0;
    localparam logic [3:0] NX_INC = 4'd1;
    localparam logic [3:0] NX_EOF = 4'd2;
    localparam logic [3:0] NX_INC_EOF = 4'd3;
    localparam logic [3:0] NX_EOF_FU = 4'd4;
    localparam logic [3:0] NX_INC_EOF_FU = 4'd5;
    localparam logic [3:0] NX_INC_EOF_Z = 4'd6;
    localparam logic [3:0] NX_INC_EOF_NZ = 4'd7;
    localparam logic [3:0] NX_JCB = 4'd8;
    localparam logic [3:0] NX_UPDATE_FLAGS = 4'd9;
    localparam logic [3:0] NX_NOP = 4'd10;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC = 2'd2,
        S_CBDEC = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_inc;
        logic flag_upd;
        logic eof;
        logic advance;
        logic jcb;
        logic suppress;
        logic reserved;
    } nxt_ctl_t;
endpackage

// File: rtl/dzcpu_useq_if.sv
// dzcpu_useq_if: opcode fetch, LUT/ROM lookup and datapath issue signals of the sequencer
interface dzcpu_useq_if;
    import dzcpu_useq_pkg::*;
    logic [7:0] iMop;
    logic iMopValid;
    logic [7:0] oMop;
    logic [UPC_W-1:0] iFlowIdx;
    logic [UPC_W-1:0] iCbFlowIdx;
    logic [UPC_W-1:0] oUopAddr;
    logic [UOP_W-1:0] iUop;
    logic iStall;
    logic iFlagZ;
    logic iIntReq;
    logic [UPC_W-1:0] iIntFlowIdx;
    logic oIntAck;
    logic oExecValid;
    logic [4:0] oExecOp;
    logic [3:0] oExecOperand;
    logic oPcInc;
    logic oFlagUpdate;
    logic oEof;
    logic oCbMode;
    logic oBusy;
    logic oUcodeErr;

    modport master (
        input iMop, iMopValid, iFlowIdx, iCbFlowIdx, iUop, iStall, iFlagZ, iIntReq, iIntFlowIdx,
        output oMop, oUopAddr, oIntAck, oExecValid, oExecOp, oExecOperand, oPcInc, oFlagUpdate,
        output oEof, oCbMode, oBusy, oUcodeErr
    );

    modport slave (
        output iMop, iMopValid, iFlowIdx, iCbFlowIdx, iUop, iStall, iFlagZ, iIntReq, iIntFlowIdx,
        input oMop, oUopAddr, oIntAck, oExecValid, oExecOp, oExecOperand, oPcInc, oFlagUpdate,
        input oEof, oCbMode, oBusy, oUcodeErr
    );
endinterface

// File: rtl/dzcpu_useq_nxtdec.sv
// dzcpu_useq_nxtdec: decodes a uop next-field (plus Z flag) into sequencer controls
module dzcpu_useq_nxtdec
    import dzcpu_useq_pkg::*;
(
    input  logic [3:0] nxt,
    input  logic       flag_z,
    output nxt_ctl_t   ctl
);
    logic taken;

    always_comb begin
        ctl = '0;
        taken = (nxt == NX_INC_EOF_Z) ? flag_z : !flag_z;
        case (nxt)
            NX_OP, NX_NOP: ctl.advance = 1'b1;
            NX_INC: begin
                ctl.pc_inc = 1'b1;
                ctl.advance = 1'b1;
            end
            NX_UPDATE_FLAGS: begin
                ctl.flag_upd = 1'b1;
                ctl.advance = 1'b1;
            end
            NX_EOF: ctl.eof = 1'b1;
            NX_INC_EOF: begin
                ctl.pc_inc = 1'b1;
                ctl.eof = 1'b1;
            end
            NX_EOF_FU: begin
                ctl.eof = 1'b1;
                ctl.flag_upd = 1'b1;
            end
            NX_INC_EOF_FU: begin
                ctl.pc_inc = 1'b1;
                ctl.eof = 1'b1;
                ctl.flag_upd = 1'b1;
            end
            // conditional exit: a taken branch ends the flow without issuing the uop
            NX_INC_EOF_Z, NX_INC_EOF_NZ: begin
                ctl.pc_inc = 1'b1;
                ctl.eof = taken;
                ctl.suppress = taken;
                ctl.advance = !taken;
            end
            NX_JCB: begin
                ctl.pc_inc = 1'b1;
                ctl.jcb = 1'b1;
                ctl.suppress = 1'b1;
            end
            default: begin
                ctl.reserved = 1'b1;
                ctl.advance = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer walking the uop ROM from LUT-selected flow starts
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int MAX_FLOW_LEN = DEF_MAX_FLOW_LEN
) (
    input logic iClock,
    input logic iReset,
    dzcpu_useq_if.master bus
);
    localparam int CNT_W = $clog2(MAX_FLOW_LEN);

    state_t state, state_nx;
    logic [UPC_W-1:0] upc;
    logic [7:0] rmop;
    logic [CNT_W-1:0] cnt;
    logic err, cb;
    nxt_ctl_t ctl;
    logic run, runaway, last, valid;

    dzcpu_useq_nxtdec u_nxtdec (
        .nxt(bus.iUop[NXT_HI:NXT_LO]),
        .flag_z(bus.iFlagZ),
        .ctl(ctl)
    );

    assign run = state == S_EXEC && !bus.iStall;
    assign runaway = run && !ctl.eof && cnt == CNT_W'(MAX_FLOW_LEN - 1);
    assign last = run && (ctl.eof || runaway);
    assign valid = run && !ctl.suppress;

    always_ff @(posedge iClock)
        state <= iReset ? S_FETCH : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: state_nx = bus.iIntReq ? S_EXEC : bus.iMopValid ? S_DECODE : S_FETCH;
            S_DECODE, S_CBDEC: state_nx = S_EXEC;
            default: state_nx = !run ? S_EXEC : last ? S_FETCH : ctl.jcb ? S_CBDEC : S_EXEC;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            upc <= '0;
            rmop <= '0;
            cnt <= '0;
            err <= 1'b0;
            cb <= 1'b0;
        end else begin
            if (state == S_FETCH && bus.iIntReq)
                upc <= bus.iIntFlowIdx;
            else if (state == S_DECODE)
                upc <= bus.iFlowIdx;
            else if (state == S_CBDEC)
                upc <= bus.iCbFlowIdx;
            else if (run && ctl.advance && !runaway)
                upc <= upc + 1'b1;
            // second CB byte is on iMop while the JCB uop executes
            if ((state == S_FETCH && !bus.iIntReq && bus.iMopValid) || (run && ctl.jcb && !runaway))
                rmop <= bus.iMop;
            if (state == S_FETCH || state == S_DECODE)
                cnt <= '0;
            else if (run)
                cnt <= cnt + 1'b1;
            if (runaway || (run && ctl.reserved))
                err <= 1'b1;
            if (last)
                cb <= 1'b0;
            else if (run && ctl.jcb)
                cb <= 1'b1;
        end
    end

    always_comb begin
        bus.oIntAck = state == S_FETCH && bus.iIntReq;
        bus.oBusy = state != S_FETCH;
        bus.oExecValid = valid;
        bus.oExecOp = valid ? bus.iUop[OP_HI:OP_LO] : '0;
        bus.oExecOperand = valid ? bus.iUop[OPR_HI:OPR_LO] : '0;
        bus.oPcInc = run && ctl.pc_inc;
        bus.oFlagUpdate = run && ctl.flag_upd;
        bus.oEof = last;
        bus.oCbMode = cb;
        bus.oUcodeErr = err;
        bus.oMop = rmop;
        bus.oUopAddr = upc;
    end
endmodule
